// File: rtl/window_fetch_scheduler_if.sv
// Handshake bundle between the window fetch scheduler and its consumer.
// Master drives control and ready; slave is the scheduler.
interface window_fetch_scheduler_if #(
  parameter int AW = 14,
  parameter int CW = 7
);
  logic          start;
  logic          abort;
  logic          ready_in;
  logic [AW-1:0] addr_r;
  logic          valid_out;
  logic          pad_out;
  logic [1:0]    lane_out;
  logic [CW-1:0] col_out;
  logic          strip_last_out;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, ready_in,
    input  addr_r, valid_out, pad_out, lane_out,
    input  col_out, strip_last_out, busy, done
  );

  modport slave (
    input  start, abort, ready_in,
    output addr_r, valid_out, pad_out, lane_out,
    output col_out, strip_last_out, busy, done
  );
endinterface

// File: rtl/window_fetch_scheduler.sv
// Strip-wise tensor_ram read sequencer feeding the sliding window.
// Issues one address per slot and tags each returned word.
module window_fetch_scheduler #(
  parameter int IMG_W      = 96,
  parameter int IMG_H      = 96,
  parameter int STRIP_H    = 4,
  parameter int ROW_STRIDE = 1,
  parameter int AW         = $clog2(IMG_W*IMG_H),
  parameter int CW         = $clog2(IMG_W)
) (
  input logic clk,
  input logic reset,
  window_fetch_scheduler_if.slave bus
);

  localparam int RW = $clog2(IMG_H + STRIP_H) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, nxt;
  logic [RW-1:0] strip_row;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [1:0]    lane;
  logic [AW:0]   lin;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] held_addr;
  logic          pad;
  logic          last_lane;
  logic          last_col;
  logic          last_strip;
  logic          stall;
  logic          issue;
  logic          kill;

  // Position decode for the beat the issue counters point at.
  always_comb begin
    row        = strip_row + RW'(lane);
    lin        = (AW+1)'(row) * (AW+1)'(IMG_W) + (AW+1)'(col);
    pad        = (row >= RW'(IMG_H)) || lin[AW];
    issue_addr = pad ? '0 : lin[AW-1:0];
    last_lane  = lane == 2'(STRIP_H - 1);
    last_col   = col == CW'(IMG_W - 1);
    last_strip = (strip_row + RW'(ROW_STRIDE)) >= RW'(IMG_H);
    stall      = bus.valid_out && !bus.ready_in;
    kill       = bus.abort && (state != IDLE);
    issue      = (state == ISSUE) && !stall && !bus.abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = ISSUE;
      ISSUE:   if (issue && last_lane && last_col && last_strip) nxt = DRAIN;
      DRAIN:   if (bus.ready_in) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = IDLE;
  end

  // Outputs; a stalled beat re-presents its address so dout stays put.
  always_comb begin
    bus.busy = (state == ISSUE) || (state == DRAIN);
    bus.done = state == DONE;
    if (stall)               bus.addr_r = held_addr;
    else if (state == ISSUE) bus.addr_r = issue_addr;
    else                     bus.addr_r = '0;
  end

  // Traversal counters, beat valid and tags aligned with ram latency.
  always_ff @(posedge clk) begin
    if (reset || kill) begin
      strip_row     <= '0;
      col           <= '0;
      lane          <= '0;
      held_addr     <= '0;
      bus.valid_out <= 1'b0;
      if (reset) begin
        bus.pad_out        <= 1'b0;
        bus.lane_out       <= '0;
        bus.col_out        <= '0;
        bus.strip_last_out <= 1'b0;
      end
    end else if (issue) begin
      bus.valid_out      <= 1'b1;
      bus.pad_out        <= pad;
      bus.lane_out       <= lane;
      bus.col_out        <= col;
      bus.strip_last_out <= last_lane && last_col;
      held_addr          <= issue_addr;
      if (!last_lane) begin
        lane <= lane + 2'd1;
      end else begin
        lane <= '0;
        if (!last_col) begin
          col <= col + CW'(1);
        end else begin
          col       <= '0;
          strip_row <= last_strip ? '0 : strip_row + RW'(ROW_STRIDE);
        end
      end
    end else if (!stall) begin
      bus.valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_fetch_scheduler.sv
// Directed bench: two scheduler geometries, stall, abort,
// repeated start and mid-pass reset.
module tb_window_fetch_scheduler;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  int   sel   = 1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  window_fetch_scheduler_if #(.AW(4), .CW(2)) i1 ();
  window_fetch_scheduler_if #(.AW(4), .CW(2)) i2 ();

  assign i1.start    = start && (sel == 1);
  assign i1.abort    = abort && (sel == 1);
  assign i1.ready_in = ready;
  assign i2.start    = start && (sel == 2);
  assign i2.abort    = abort && (sel == 2);
  assign i2.ready_in = ready;

  window_fetch_scheduler #(
    .IMG_W(4), .IMG_H(4), .STRIP_H(4), .ROW_STRIDE(4)
  ) d1 (
    .clk(clk), .reset(reset), .bus(i1)
  );

  window_fetch_scheduler #(
    .IMG_W(3), .IMG_H(3), .STRIP_H(4), .ROW_STRIDE(1)
  ) d2 (
    .clk(clk), .reset(reset), .bus(i2)
  );

  logic [3:0] o_addr;
  logic [1:0] o_lane;
  logic [1:0] o_col;
  logic       o_valid, o_pad, o_last, o_busy, o_done;

  always_comb begin
    o_addr  = i1.addr_r;
    o_lane  = i1.lane_out;
    o_col   = i1.col_out;
    o_valid = i1.valid_out;
    o_pad   = i1.pad_out;
    o_last  = i1.strip_last_out;
    o_busy  = i1.busy;
    o_done  = i1.done;
    if (sel == 2) begin
      o_addr  = i2.addr_r;
      o_lane  = i2.lane_out;
      o_col   = i2.col_out;
      o_valid = i2.valid_out;
      o_pad   = i2.pad_out;
      o_last  = i2.strip_last_out;
      o_busy  = i2.busy;
      o_done  = i2.done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected tags of beat k in traversal order.
  task automatic bm(input int k, w, h, sh, rs,
                    output int a, p, l, c, e);
    int s, r, row;
    s   = k / (w * sh);
    r   = k % (w * sh);
    c   = r / sh;
    l   = r % sh;
    row = s * rs + l;
    p   = (row >= h) ? 1 : 0;
    a   = p ? 0 : row * w + c;
    e   = (c == w - 1 && l == sh - 1) ? 1 : 0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " addr"},  o_addr, 0);
    chk({nm, " valid"}, o_valid, 0);
    chk({nm, " pad"},   o_pad, 0);
    chk({nm, " lane"},  o_lane, 0);
    chk({nm, " col"},   o_col, 0);
    chk({nm, " last"},  o_last, 0);
    chk({nm, " busy"},  o_busy, 0);
    chk({nm, " done"},  o_done, 0);
  endtask

  task automatic run(input int s, w, h, sh, rs,
                     input int stall_at, stall_len, abort_at, rst_at,
                     input bit spam, input string nm);
    int total, k, i, st, cyc, a, p, l, c, e;
    total = ((h + rs - 1) / rs) * w * sh;
    k = 0; i = 0; st = 0; cyc = 0;
    sel = s;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = spam;
    chk({nm, " busy0"}, o_busy, 1);
    chk({nm, " lat0"}, o_valid, 0);
    while (k < total && cyc < 1000) begin
      if (cyc == 1) chk({nm, " lat1"}, o_valid, 1);
      ready = 1'b1;
      if (o_valid) begin
        bm(k, w, h, sh, rs, a, p, l, c, e);
        chk({nm, " lane"}, o_lane, l);
        chk({nm, " col"}, o_col, c);
        chk({nm, " pad"}, o_pad, p);
        chk({nm, " slast"}, o_last, e);
        if (k == abort_at) begin
          ready = 1'b0;
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          ready = 1'b1;
          start = 1'b0;
          chk({nm, " ab valid"}, o_valid, 0);
          chk({nm, " ab busy"}, o_busy, 0);
          chk({nm, " ab done"}, o_done, 0);
          @(negedge clk);
          chk({nm, " ab done2"}, o_done, 0);
          return;
        end
        if (k == rst_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          start = 1'b0;
          chk_idle({nm, " rst"});
          return;
        end
        if (k == stall_at && st < stall_len) begin
          ready = 1'b0;
          st++;
        end
      end
      #1;
      if (o_valid && !ready) begin
        bm(k, w, h, sh, rs, a, p, l, c, e);
        chk({nm, " hold"}, o_addr, a);
      end else if (i < total) begin
        bm(i, w, h, sh, rs, a, p, l, c, e);
        chk({nm, " addr"}, o_addr, a);
        i++;
      end
      if (o_valid && ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " beats"}, k, total);
    chk({nm, " done"}, o_done, 1);
    chk({nm, " busyD"}, o_busy, 0);
    chk({nm, " validD"}, o_valid, 0);
    @(negedge clk);
    start = 1'b0;
    chk({nm, " done1"}, o_done, 0);
    chk({nm, " idle"}, o_busy, 0);
    @(negedge clk);
    chk({nm, " idle2"}, o_busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sel = 1;
    chk_idle("reset1");
    sel = 2;
    chk_idle("reset2");

    run(1, 4, 4, 4, 4, -1, 0, -1, -1, 1'b0, "s1");
    run(2, 3, 3, 4, 1, -1, 0, -1, -1, 1'b0, "s2");
    run(1, 4, 4, 4, 4, 4, 3, -1, -1, 1'b0, "s3");
    run(1, 4, 4, 4, 4, -1, 0, 6, -1, 1'b0, "s4ab");
    run(1, 4, 4, 4, 4, -1, 0, -1, -1, 1'b0, "s4re");
    run(1, 4, 4, 4, 4, -1, 0, -1, -1, 1'b1, "s5");
    run(1, 4, 4, 4, 4, -1, 0, -1, 8, 1'b0, "s6rs");
    run(1, 4, 4, 4, 4, -1, 0, -1, -1, 1'b0, "s6re");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/window_fetch_scheduler.md
Name: window_fetch_scheduler

Overview:
Read-side sequencer for the tensor_ram → sliding_window path. It replaces the free-running pixel_reader. It walks the image in horizontal strips of STRIP_H rows, column by column, and issues one tensor_ram read address per cycle. Each returned 32-bit word is tagged with its lane (A0..A3 row), a bottom-edge padding flag, and an end-of-strip marker. It supports downstream backpressure, abort, and a done pulse.

Parameters:
IMG_W, 96, image width in words (one 32-bit word = one pixel, 4 int8 channels)
IMG_H, 96, image height in rows
STRIP_H, 4, rows per strip (= window lanes A0..A3)
ROW_STRIDE, 1, row advance between successive strips (1..STRIP_H)
AW, $clog2(IMG_W*IMG_H), address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin a full-image pass; ignored unless idle
abort  in  1  cancel current pass
ready_in  in  1  downstream accepts the beat on valid_out this cycle
addr_r  out  AW  tensor_ram read address (1-cycle read latency)
valid_out  out  1  tensor_ram dout holds a beat for downstream
pad_out  out  1  beat row is >= IMG_H; downstream substitutes zero
lane_out  out  2  row within strip (0..STRIP_H-1) of the current beat
col_out  out  $clog2(IMG_W)  column of the current beat
strip_last_out  out  1  current beat is the last of its strip (col=IMG_W-1, lane=STRIP_H-1)
busy  out  1  pass in progress
done  out  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset: state IDLE; all counters 0; addr_r=0, valid_out=0, pad_out=0, lane_out=0, col_out=0, strip_last_out=0, busy=0, done=0. Reset mid-pass discards the pass with no done pulse.
- Traversal order:
  - strip_row = s*ROW_STRIDE for s = 0.. while strip_row < IMG_H; number of strips = ceil(IMG_H/ROW_STRIDE).
  - Within a strip: col 0..IMG_W-1 (outer loop), lane 0..STRIP_H-1 (inner loop).
  - Address = (strip_row+lane)*IMG_W + col, computed with AW+1 bits before range check.
  - If strip_row+lane >= IMG_H: the beat is a pad beat, addr_r=0, pad_out=1.
- States and transitions:
  - IDLE: start → ISSUE.
  - ISSUE: presents one address per accepted slot; after the final address is issued → DRAIN.
  - DRAIN: final beat waits for acceptance → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Timing:
  - start sampled at cycle t → addr_r = first address during t+1 → valid_out=1 at t+2 with tag outputs.
  - Tag outputs (pad_out, lane_out, col_out, strip_last_out) are registered alongside valid_out and describe the beat currently on dout.
- Handshake:
  - A beat is transferred when valid_out && ready_in.
  - When valid_out=1 and ready_in=0, all state freezes.
  - While frozen, addr_r re-presents the address of the beat currently on valid_out, so dout stays stable next cycle (combinational mux: ready_in ? next_addr : held_addr).
  - valid_out never drops without acceptance, except on abort or reset.
- Throughput: 1 beat/cycle with ready_in held high; total beats = strips*IMG_W*STRIP_H.
- busy: 1 in ISSUE and DRAIN, 0 in IDLE and DONE.
- start while busy: ignored.
- abort: in any non-IDLE state → IDLE next cycle. valid_out=0 and busy=0 next cycle, no done pulse. abort has priority over ready_in and start in the same cycle.
- Wrap: col returns to 0 and lane to 0 at each strip boundary. strip_last_out=1 on the final beat of every strip, including the final strip.
- Back-to-back passes: start asserted in the DONE cycle is ignored; the next pass needs start in IDLE.

Test Plan:
1. IMG_W=4, IMG_H=4, STRIP_H=4, ROW_STRIDE=4, ready_in=1, start pulse → 16 beats; addr_r sequence 0,4,8,12,1,5,9,13,...,15; valid_out first at start+2; strip_last_out on beat 16; done exactly one cycle after the last beat; no pad.
2. IMG_W=3, IMG_H=3, STRIP_H=4, ROW_STRIDE=1 → 3 strips × 12 beats = 36 beats; strip 0 lane 3 has pad_out=1; strip 2 lanes 1..3 have pad_out=1 with addr_r=0; every non-pad address < 9.
3. Same as scenario 1, but ready_in=0 for 3 cycles at beat 5 (addr 1) → valid_out held; lane_out=0, col_out=1, addr_r=1 for all 3 cycles; beat 6 is addr 5 after release; no beats lost or duplicated; total 16.
4. abort at beat 7 while ready_in=0 → next cycle valid_out=0, busy=0, no done; a fresh start then restarts at addr 0.
5. start asserted repeatedly during a pass → ignored; exactly one done; beat count unchanged (16).
6. reset asserted mid-pass at beat 9 → next cycle all outputs at reset values; subsequent start yields a full, correct 16-beat pass.
